// File: rtl/kbd_pkg.sv
// Shared types, scan-code constants and Set-2 to ASCII lookup for kbd_scancode_fsm.
package kbd_pkg;

  typedef enum logic [1:0] {StIdle, StPop, StGap} state_e;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Lower-case letters, digit row and space; everything else maps to 8'h00.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = 8'h61;  8'h32: a = 8'h62;  8'h21: a = 8'h63;  8'h23: a = 8'h64;
      8'h24: a = 8'h65;  8'h2B: a = 8'h66;  8'h34: a = 8'h67;  8'h33: a = 8'h68;
      8'h43: a = 8'h69;  8'h3B: a = 8'h6A;  8'h42: a = 8'h6B;  8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D;  8'h31: a = 8'h6E;  8'h44: a = 8'h6F;  8'h4D: a = 8'h70;
      8'h15: a = 8'h71;  8'h2D: a = 8'h72;  8'h1B: a = 8'h73;  8'h2C: a = 8'h74;
      8'h3C: a = 8'h75;  8'h2A: a = 8'h76;  8'h1D: a = 8'h77;  8'h22: a = 8'h78;
      8'h35: a = 8'h79;  8'h1A: a = 8'h7A;
      8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
      8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
      8'h3E: a = 8'h38;  8'h46: a = 8'h39;
      8'h29: a = 8'h20;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to 7-segment pattern (bit7 = dp, gfedcba below), with blanking and polarity select.
module hex7seg #(
  parameter bit SEG_INV = 1'b1
) (
  input  logic [3:0] value,
  input  logic       blank,
  output logic [7:0] seg
);

  logic [7:0] pat;

  always_comb begin
    pat = 8'h00;
    if (!blank) begin
      case (value)
        4'h0: pat = 8'h3F;  4'h1: pat = 8'h06;  4'h2: pat = 8'h5B;  4'h3: pat = 8'h4F;
        4'h4: pat = 8'h66;  4'h5: pat = 8'h6D;  4'h6: pat = 8'h7D;  4'h7: pat = 8'h07;
        4'h8: pat = 8'h7F;  4'h9: pat = 8'h6F;  4'hA: pat = 8'h77;  4'hB: pat = 8'h7C;
        4'hC: pat = 8'h39;  4'hD: pat = 8'h5E;  4'hE: pat = 8'h79;  4'hF: pat = 8'h71;
        default: pat = 8'h00;
      endcase
    end
    seg = SEG_INV ? ~pat : pat;
  end

endmodule

// File: rtl/kbd_scancode_fsm.sv
// PS/2 Set-2 byte consumer: pops the keyboard FIFO, decodes E0/F0 prefixes, tracks the held key.
// Optional KBD_TYPEMATIC_FILTER_EN: auto-repeat makes of the held key do not bump press_cnt.
module kbd_scancode_fsm
  import kbd_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter bit          SEG_INV = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic [CNT_W-1:0] press_cnt,
  output logic             ovf_seen,
  output logic [7:0]       seg0,
  output logic [7:0]       seg1,
  output logic [7:0]       seg2,
  output logic [7:0]       seg3,
  output logic [7:0]       seg4,
  output logic [7:0]       seg5
);

  state_e state_q, state_d;
  logic [7:0] byte_q, byte_d;
  logic nd_q, nd_d;
  logic ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
  logic valid_q, valid_d, kext_q, kext_d, ovf_q, ovf_d;
  logic [7:0] code_q, code_d, ascii_q, ascii_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic is_drop, is_repeat;

  assign is_drop = (byte_q == SC_BAT) || (byte_q == SC_ACK) || (byte_q == SC_ECHO) ||
                   (byte_q == 8'h00) || (byte_q == 8'hFF);

`ifdef KBD_TYPEMATIC_FILTER_EN
  assign is_repeat = valid_q && (byte_q == code_q) && (ext_pend_q == kext_q);
`else
  assign is_repeat = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    nd_d       = 1'b1;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    valid_d    = valid_q;
    code_d     = code_q;
    kext_d     = kext_q;
    ascii_d    = ascii_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q | kb_overflow;
    case (state_q)
      StIdle: begin
        if (kb_ready) begin
          byte_d  = kb_data;
          nd_d    = 1'b0;
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StGap;
        if (byte_q == SC_EXT) begin
          ext_pend_d = 1'b1;
        end else if (byte_q == SC_BRK) begin
          brk_pend_d = 1'b1;
        end else begin
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          if (is_drop) begin
            // Controller chatter: discard and forget any half-received prefix.
          end else if (brk_pend_q) begin
            if ((byte_q == code_q) && (ext_pend_q == kext_q)) valid_d = 1'b0;
          end else begin
            valid_d = 1'b1;
            code_d  = byte_q;
            kext_d  = ext_pend_q;
            ascii_d = ext_pend_q ? 8'h00 : scan_to_ascii(byte_q);
            if (!is_repeat) cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_q     <= 8'h00;
      nd_q       <= 1'b1;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      code_q     <= 8'h00;
      kext_q     <= 1'b0;
      ascii_q    <= 8'h00;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_q     <= byte_d;
      nd_q       <= nd_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      kext_q     <= kext_d;
      ascii_q    <= ascii_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

  assign kb_nextdata_n = nd_q;
  assign key_valid     = valid_q;
  assign key_code      = code_q;
  assign key_ext       = kext_q;
  assign key_ascii     = ascii_q;
  assign press_cnt     = cnt_q;
  assign ovf_seen      = ovf_q;

  // Only the low two hex digits of the counter are shown.
  logic [7:0] cnt8;
  if (CNT_W >= 8) begin : g_cnt_wide
    assign cnt8 = cnt_q[7:0];
  end else begin : g_cnt_narrow
    assign cnt8 = {{(8 - CNT_W){1'b0}}, cnt_q};
  end

  logic [3:0] nib [6];
  logic [5:0] blk;
  logic [7:0] seg_w [6];

  always_comb begin
    nib[0] = code_q[3:0];
    nib[1] = code_q[7:4];
    nib[2] = ascii_q[3:0];
    nib[3] = ascii_q[7:4];
    nib[4] = cnt8[3:0];
    nib[5] = cnt8[7:4];
    blk    = {2'b00, {4{~valid_q}}};
  end

  for (genvar i = 0; i < 6; i++) begin : g_seg
    hex7seg #(
      .SEG_INV(SEG_INV)
    ) u_hex (
      .value(nib[i]),
      .blank(blk[i]),
      .seg  (seg_w[i])
    );
  end

  assign seg0 = seg_w[0];
  assign seg1 = seg_w[1];
  assign seg2 = seg_w[2];
  assign seg3 = seg_w[3];
  assign seg4 = seg_w[4];
  assign seg5 = seg_w[5];

endmodule
